// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small receive FIFO, with sticky
// overrun and framing-error flags.
//
// Ports:
//   clk_i        single rising-edge clock
//   resetn_i     synchronous active-low reset
//   rxd_i        asynchronous serial line, idle high
//   rd_i         one-cycle pop strobe
//   clr_i        one-cycle strobe clearing the sticky flags
//   rdata_o[7:0] byte at the FIFO head, 0x00 when empty
//   valid_o      FIFO non-empty
//   overrun_o    sticky: a received byte was dropped on a full FIFO
//   frame_err_o  sticky: a stop bit was sampled low
//
// Receiver states:
//   state   | meaning
//   S_IDLE  | waiting for a synchronized falling edge on the line
//   S_START | timing to mid start bit; a high line there is a glitch
//   S_DATA  | sampling 8 data bits LSB-first at mid-bit
//   S_STOP  | sampling the stop bit; push the byte or flag a framing error
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_LOG2    = 2
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       rxd_i,
  input  logic       rd_i,
  input  logic       clr_i,
  output logic [7:0] rdata_o,
  output logic       valid_o,
  output logic       overrun_o,
  output logic       frame_err_o
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PW    = FIFO_LOG2 + 1;
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  state_t        state_q;
  logic [15:0]   cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic stop_sample, push, empty, full, do_pop, do_push;

  // Stop-bit sample happens on the edge that ends the S_STOP/count-0 cycle;
  // the FIFO write shares that edge so the byte is visible one cycle later.
  assign stop_sample = (state_q == S_STOP) && (cnt_q == 16'd0);
  assign push        = stop_sample && rx_s2_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
  assign do_pop  = rd_i && !empty;
  // On a full FIFO a simultaneous pop frees the head slot, which is exactly
  // the slot the write pointer addresses.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      rx_s1_q   <= rxd_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (state_q)
        S_IDLE: begin
          // Edge-triggered start: a line held low (break) never re-arms.
          if (rx_prev_q && !rx_s2_q) begin
            cnt_q   <= HALF_LOAD;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == 16'd0) begin
            if (rx_s2_q) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q     <= BIT_LOAD;
              bit_idx_q <= 3'd0;
              state_q   <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 16'd0) begin
            shift_q   <= {rx_s2_q, shift_q[7:1]};
            cnt_q     <= BIT_LOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 16'd0) state_q <= S_IDLE;
          else                cnt_q   <= cnt_q - 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (clr_i) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    // Setting events are applied last so they win over a coincident clear.
    if (push && full && !do_pop)  overrun_d   = 1'b1;
    if (stop_sample && !rx_s2_q)  frame_err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-empty FIFO.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= shift_q;
  end

  assign rdata_o     = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_LOG2-1:0]];
  assign valid_o     = !empty;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rdata;
  logic       valid, ovr, ferr;

  int n_tests = 0;
  int n_fail  = 0;
  logic v_pre, v_post;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(2)) dut (
    .clk_i(clk), .resetn_i(resetn), .rxd_i(rxd), .rd_i(rd), .clr_i(clr),
    .rdata_o(rdata), .valid_o(valid), .overrun_o(ovr), .frame_err_o(ferr)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_SEND, OP_READ, OP_CLR} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] d;
    logic       stop;
    logic       ev;
    logic [7:0] ed;
    logic       eo;
    logic       ef;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ev, input logic [7:0] ed,
                           input logic eo, input logic ef);
    check({name, ".valid"}, valid, ev);
    check({name, ".rdata"}, rdata, ed);
    check({name, ".overrun"}, ovr, eo);
    check({name, ".frame_err"}, ferr, ef);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // One 8N1 frame, one bit per CPB cycles, driven on negedges. With the
  // 2-flop synchronizer plus edge register the stop sample lands on the edge
  // between negedge 154 and 155. rd_k/clr_k assert that strobe for one cycle
  // starting at negedge k; rst_k pulses reset for two cycles and abandons.
  task automatic frame(input logic [7:0] d, input logic stop,
                       input int rd_k, input int clr_k, input int rst_k);
    int b;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      if (k == 154) v_pre = valid;
      if (k == 155) v_post = valid;
      if (k == rst_k) begin
        resetn = 1'b0;
        rxd    = 1'b1;
        rd     = 1'b0;
        clr    = 1'b0;
        idle(2);
        resetn = 1'b1;
        return;
      end
      b   = k / CPB;
      rxd = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      rd  = (k == rd_k);
      clr = (k == clr_k);
    end
    @(negedge clk);
    rd  = 1'b0;
    clr = 1'b0;
    rxd = 1'b1;
    idle(4);
  endtask

  initial begin
    tbl[0]  = '{OP_SEND, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[1]  = '{OP_READ, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{OP_SEND, 8'hA3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{OP_CLR,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{OP_SEND, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[5]  = '{OP_SEND, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6]  = '{OP_SEND, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[7]  = '{OP_SEND, 8'h04, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[8]  = '{OP_SEND, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[9]  = '{OP_READ, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[10] = '{OP_READ, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[11] = '{OP_READ, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[12] = '{OP_READ, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[13] = '{OP_READ, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[14] = '{OP_CLR,  8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[15] = '{OP_SEND, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[16] = '{OP_READ, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset state
    idle(3);
    check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    resetn = 1'b1;
    idle(3);

    // Push timing: valid rises exactly on the edge after the stop sample
    frame(8'h55, 1'b1, -1, -1, -1);
    check("t29.v_before_stop", v_pre, 1'b0);
    check("t29.v_after_stop", v_post, 1'b1);
    check("t29.rdata", rdata, 8'h55);
    pulse_rd();
    check("t29.valid_after_rd", valid, 1'b0);

    // Start-bit glitch: 4 low cycles are rejected at mid start bit
    @(negedge clk);
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    check_all("glitch", 1'b0, 8'h00, 1'b0, 1'b0);

    // Table-driven sequence
    for (int i = 0; i < NV; i++) begin
      case (tbl[i].op)
        OP_SEND: frame(tbl[i].d, tbl[i].stop, -1, -1, -1);
        OP_READ: pulse_rd();
        default: pulse_clr();
      endcase
      check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].ef);
    end

    // Held break yields exactly one framing error
    rxd = 1'b0;
    idle(400);
    check("break.ferr_set", ferr, 1'b1);
    pulse_clr();
    idle(300);
    check("break.ferr_once", ferr, 1'b0);
    rxd = 1'b1;
    idle(4);
    check_all("break.end", 1'b0, 8'h00, 1'b0, 1'b0);

    // Clear coinciding with a framing error: set wins
    frame(8'h3C, 1'b0, -1, 154, -1);
    check("clr_vs_set.ferr", ferr, 1'b1);
    pulse_clr();
    check("clr_vs_set.cleared", ferr, 1'b0);

    // Push and pop on the same edge while empty: pop ignored, byte kept
    frame(8'hC6, 1'b1, 154, -1, -1);
    check("empty_rd_push.v_post", v_post, 1'b1);
    check_all("empty_rd_push", 1'b1, 8'hC6, 1'b0, 1'b0);
    pulse_rd();
    check("empty_rd_push.drained", valid, 1'b0);

    // Full FIFO, pop on the push edge of 0x14: no overrun
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b1, -1, -1, -1);
    check_all("full", 1'b1, 8'h10, 1'b0, 1'b0);
    frame(8'h14, 1'b1, 154, -1, -1);
    check_all("full_rd_push", 1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_rd_push.read%0d", i), rdata, 8'h11 + 8'(i));
      pulse_rd();
    end
    check_all("full_rd_push.empty", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of data bit 3 of 0x7E, then receive 0x42 only
    frame(8'h7E, 1'b1, -1, -1, 70);
    check_all("midreset", 1'b0, 8'h00, 1'b0, 1'b0);
    idle(200);
    check_all("midreset.quiet", 1'b0, 8'h00, 1'b0, 1'b0);
    frame(8'h42, 1'b1, -1, -1, -1);
    check_all("midreset.rx42", 1'b1, 8'h42, 1'b0, 1'b0);
    pulse_rd();
    check("midreset.only42", valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_LOG2, default 2, log2 of receive FIFO depth (depth 4).
REQ-003 SHALL have port clk_i, input, 1, the single clock; every flop is rising-edge.
REQ-004 SHALL have port resetn_i, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have port rxd_i, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port rd_i, input, 1, one-cycle pop strobe from the IO read decode.
REQ-007 SHALL have port clr_i, input, 1, one-cycle strobe that clears the sticky error flags.
REQ-008 SHALL have port rdata_o, output, 8, byte at the FIFO head; 0x00 when the FIFO is empty.
REQ-009 SHALL have port valid_o, output, 1, FIFO non-empty.
REQ-010 SHALL have port overrun_o, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err_o, output, 1, sticky flag: a stop bit was sampled low.

Function
REQ-012 SHALL pass rxd_i through a 2-flop synchronizer (reset value 1) and use only the synchronized value downstream.
REQ-013 SHALL implement receiver states IDLE, START, DATA and STOP with a 16-bit down-counter and a 3-bit bit index.
REQ-014 IDLE SHALL enter START only on a synchronized falling edge (previous 1, current 0), loading the counter with CLKS_PER_BIT/2-1 (integer division).
REQ-015 START at counter 0 SHALL return to IDLE if the line is 1 (glitch, nothing recorded), else load CLKS_PER_BIT-1, clear the bit index and enter DATA.
REQ-016 DATA at counter 0 SHALL shift in the sampled bit LSB-first and reload CLKS_PER_BIT-1; after bit index 7 it SHALL enter STOP.
REQ-017 STOP at counter 0 SHALL push the byte if the line is 1, else discard it and set frame_err_o; both cases return to IDLE.
REQ-018 After a framing error, no new frame SHALL start until the line has been seen at 1 (falling-edge rule, REQ-014); a held break yields exactly one error.
REQ-019 A push SHALL make the byte visible on rdata_o and valid_o on the cycle after the STOP-sample edge.
REQ-020 A push into a full FIFO with rd_i low SHALL drop the new byte, set overrun_o and leave FIFO contents unchanged.
REQ-021 A push and rd_i in the same cycle when full SHALL pop the head and accept the new byte; no overrun.
REQ-022 A push and rd_i in the same cycle when empty SHALL leave the FIFO empty for one cycle, then hold the new byte (pop of empty is ignored).
REQ-023 rd_i while empty SHALL be ignored, with no pointer movement.
REQ-024 FIFO pointers SHALL be FIFO_LOG2+1 bits wide and wrap modulo 2*depth; full = MSBs differ and LSBs equal.
REQ-025 clr_i SHALL clear both sticky flags; if it coincides with a setting event, the set SHALL win.
REQ-026 rdata_o SHALL be driven from registered storage; no combinational path from rxd_i to any output.

Reset
REQ-027 resetn_i low at a clock edge SHALL force IDLE, empty FIFO, valid_o=0, rdata_o=0x00, overrun_o=0, frame_err_o=0 and synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL abandon the partial byte; reception after release needs a fresh falling edge.

Verification (bench CLKS_PER_BIT=16)
REQ-029 Send 0x55 with stop=1 -> valid_o=1 and rdata_o=0x55 one cycle after the stop sample; rd_i pulse -> valid_o=0.
REQ-030 Drive rxd low for 4 cycles then high -> no push, no flag, state back to IDLE.
REQ-031 Send 0xA3 with stop bit 0 -> frame_err_o=1, FIFO empty; clr_i -> frame_err_o=0.
REQ-032 Send 0x01..0x05 without reading -> overrun_o=1; reads return 0x01,0x02,0x03,0x04, then valid_o=0.
REQ-033 With FIFO full (0x10..0x13), assert rd_i on the push cycle of 0x14 -> overrun_o=0; reads return 0x11,0x12,0x13,0x14.
REQ-034 Assert resetn_i low during DATA bit 3 of 0x7E, release, then send 0x42 -> only 0x42 is received.
